// File: rtl/operand_dispatcher_pkg.sv
// Shared definitions for the operand dispatcher: FSM encoding, defaults,
// and helpers for packing an operand pair into one FIFO word.
package operand_dispatcher_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    OUT   = 4'b1000
  } state_t;

  // Operand a occupies the upper half of a FIFO word, operand b the lower half.
  function automatic logic [2*DEFAULT_WIDTH-1:0] pack_pair(
    input logic [DEFAULT_WIDTH-1:0] a,
    input logic [DEFAULT_WIDTH-1:0] b
  );
    return {a, b};
  endfunction

endpackage

// File: rtl/operand_dispatcher_fifo.sv
// Operand-pair FIFO: DEPTH entries of 2*WIDTH bits, power-of-two depth so the
// pointers wrap naturally; level counts occupancy from 0 to DEPTH.
module op_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [2*WIDTH-1:0]     wdata,
  output logic [2*WIDTH-1:0]     rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/operand_dispatcher.sv
// Queues operand pairs and feeds them one job at a time to a multiplier
// controller, returning each product over a valid/ready handshake in order.
module operand_dispatcher
  import operand_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   core_start,
  output logic [WIDTH-1:0]       core_a,
  output logic [WIDTH-1:0]       core_b,
  input  logic                   core_done,
  input  logic [2*WIDTH-1:0]     core_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_result,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  state_t             state;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] head;

  // Full FIFO refuses pushes even when a pop happens in the same cycle.
  assign in_ready  = rst & ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign fifo_pop  = (state == IDLE) & ~fifo_empty;
  assign busy      = rst & ((state != IDLE) | ~fifo_empty);

  op_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata({in_a, in_b}),
    .rdata(head),
    .level(level),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      core_start <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            core_a     <= head[2*WIDTH-1:WIDTH];
            core_b     <= head[WIDTH-1:0];
            core_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            out_result <= core_result;
            out_valid  <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          core_start <= 1'b0;
          out_valid  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_dispatcher.sv
// Scoreboard bench for operand_dispatcher with a behavioural multiplier-core model.
module tb_operand_dispatcher;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        core_start;
  logic [7:0]  core_a;
  logic [7:0]  core_b;
  logic        core_done = 1'b0;
  logic [15:0] core_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        busy;
  logic [2:0]  level;

  operand_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .core_start(core_start), .core_a(core_a),
    .core_b(core_b), .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: pairs awaiting issue, results the core will return, results expected out.
  logic [15:0] in_res = '0;
  logic [15:0] pair_q[$];
  logic [15:0] res_q[$];
  logic [15:0] exp_q[$];
  int outstanding = 0;
  int n_start = 0;
  int n_out = 0;

  int core_lat = 10;
  bit core_hold = 0;
  bit spur = 0;
  bit rand_lat = 0;
  int ready_mode = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor + core model: samples mid-low-phase, drives core_done/out_ready for the next edge.
  initial begin
    bit          active;
    bit          prev_hold;
    bit          prev_start;
    int          cnt;
    logic [7:0]  st_a, st_b, ea, eb;
    logic [15:0] cur_res, prev_res;
    active = 0; prev_hold = 0; prev_start = 0; cnt = 0;
    st_a = '0; st_b = '0; cur_res = '0; prev_res = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pair_q.delete(); res_q.delete(); exp_q.delete();
        outstanding = 0; active = 0; prev_hold = 0; prev_start = 0;
        core_done = 1'b0;
        continue;
      end
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase

      check("busy", busy, outstanding != 0);
      check("in_ready", in_ready, level != 3'(DEPTH));
      if (prev_hold) begin
        check("out_hold_valid", out_valid, 1);
        check("out_hold_result", out_result, prev_res);
      end

      core_done = 1'b0;
      if (core_start) begin
        n_start++;
        check("start_single_cycle", prev_start, 0);
        check("start_while_out", out_valid, 0);
        check("start_has_pair", pair_q.size() != 0, 1);
        if (pair_q.size() != 0) begin
          {ea, eb} = pair_q.pop_front();
          check("core_a", core_a, ea);
          check("core_b", core_b, eb);
          st_a = core_a; st_b = core_b;
          cur_res = res_q.pop_front();
          cnt = rand_lat ? int'($urandom_range(1, 6)) : core_lat;
          active = 1;
        end
      end else if (active) begin
        check("core_a_stable", core_a, st_a);
        check("core_b_stable", core_b, st_b);
        if (!core_hold) begin
          cnt--;
          if (cnt <= 0) begin
            core_done = 1'b1;
            core_result = cur_res;
            active = 0;
          end
        end
      end else if (spur) begin
        core_done = 1'b1;
        core_result = 16'($urandom);
      end
      prev_start = core_start;

      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("out_result", out_result, exp_q.pop_front());
        n_out++;
        outstanding--;
        prev_hold = 0;
      end else if (out_valid) begin
        prev_hold = 1;
        prev_res = out_result;
      end else begin
        prev_hold = 0;
      end

      if (in_valid && in_ready) begin
        pair_q.push_back({in_a, in_b});
        res_q.push_back(in_res);
        exp_q.push_back(in_res);
        outstanding++;
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r,
                      input int maxw, output bit ok);
    in_a = a; in_b = b; in_res = r; in_valid = 1'b1; ok = 0;
    for (int i = 0; i < maxw && !ok; i++) begin
      #2;
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #2;
      done = (exp_q.size() == 0) && !busy;
    end
    check({name, "_drain"}, done, 1);
    @(negedge clk);
  endtask

  task automatic reset_zero_checks(input string name);
    check({name, "_core_start"}, core_start, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_result"}, out_result, 0);
    check({name, "_core_a"}, core_a, 0);
    check({name, "_core_b"}, core_b, 0);
    check({name, "_level"}, level, 0);
    check({name, "_in_ready"}, in_ready, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit          ok;
    logic [15:0] r;
    int          s;
    int          o;

    #1 rst = 1'b0;
    #2 reset_zero_checks("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic job with a ten-cycle core and start latency.
    ready_mode = 1; core_lat = 10;
    push(8'd13, 8'd11, 16'h1234, 20, ok);
    check("basic_push", ok, 1);
    #2 check("latency_before_start", core_start, 0);
    @(negedge clk);
    #2 check("latency_start", core_start, 1);
    drain("basic");
    check("basic_starts", n_start, 1);
    check("basic_outs", n_out, 1);

    // Fill while the core is stalled; sixth pair waits for a pop.
    core_hold = 1; s = n_start;
    for (int i = 0; i < 5; i++) begin
      push(8'(20 + i), 8'(30 + i), 16'(16'h0B00 + i), 5, ok);
      check("fill_push", ok, 1);
    end
    #2;
    check("fill_level", level, 4);
    check("fill_in_ready", in_ready, 0);
    check("fill_one_issued", n_start - s, 1);
    @(negedge clk);
    push(8'd40, 8'd41, 16'h0B05, 4, ok);
    check("fill_sixth_refused", ok, 0);
    core_hold = 0;
    push(8'd40, 8'd41, 16'h0B05, 100, ok);
    check("fill_sixth_after_pop", ok, 1);
    drain("fill");

    // Backpressure in OUT with spurious core_done pulses.
    ready_mode = 0; core_lat = 3;
    push(8'd2, 8'd3, 16'hC0DE, 10, ok);
    push(8'd4, 8'd5, 16'hBEEF, 10, ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #2 ok = out_valid;
    end
    check("bp_out_valid", ok, 1);
    r = out_result; s = n_start;
    spur = 1;
    repeat (20) @(negedge clk);
    #2;
    check("bp_valid_held", out_valid, 1);
    check("bp_result_held", out_result, r);
    check("bp_no_new_start", n_start, s);
    check("bp_level", level, 1);
    @(negedge clk);
    spur = 0; ready_mode = 1;
    drain("bp");

    // Ordering with distinct tags; five pushes wrap the pointers.
    core_lat = 2; o = n_out;
    for (int i = 0; i < 5; i++) begin
      push(8'(2 * i + 1), 8'(2 * i + 2), 16'(16'h00A1 + i), 20, ok);
      check("order_push", ok, 1);
    end
    drain("order");
    check("order_count", n_out - o, 5);

    // Push and pop on the same edge at level 2.
    ready_mode = 0; core_lat = 2;
    for (int i = 0; i < 3; i++) push(8'(50 + i), 8'(60 + i), 16'(16'h5A00 + i), 10, ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #2 ok = out_valid && (level == 3'd2);
    end
    check("sim_setup", ok, 1);
    @(negedge clk);
    ready_mode = 1;
    @(negedge clk);
    push(8'd11, 8'd12, 16'h5A03, 1, ok);
    check("sim_push", ok, 1);
    #2 check("sim_level", level, 2);
    drain("sim");

    // Reset mid-WAIT with two pairs queued, then a normal job.
    core_hold = 1; core_lat = 4;
    for (int i = 0; i < 3; i++) push(8'(70 + i), 8'(80 + i), 16'(16'h7700 + i), 10, ok);
    repeat (3) @(negedge clk);
    check("rst_pre_level", level, 2);
    rst = 1'b0;
    #1 reset_zero_checks("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1; core_hold = 0;
    @(negedge clk);
    o = n_out;
    push(8'd7, 8'd9, 16'd63, 20, ok);
    check("post_rst_push", ok, 1);
    drain("post_rst");
    check("post_rst_count", n_out - o, 1);

    // Randomized traffic with random core latency and output backpressure.
    ready_mode = 2; rand_lat = 1;
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom), 8'($urandom), 16'($urandom), 300, ok);
      check("rand_push", ok, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_dispatcher.md
OPERAND_DISPATCHER -- requirements
Module: operand_dispatcher

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the result width is 2*WIDTH.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving operand-pair FIFO entries; legal values are powers of two >= 2.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 The block SHALL have port in_ready  output  1  FIFO can accept a pair.
REQ-007 The block SHALL have ports in_a, in_b  input  WIDTH each  operands.
REQ-008 The block SHALL have port core_start  output  1  start pulse to the multiplier controller.
REQ-009 The block SHALL have ports core_a, core_b  output  WIDTH each  operands held for the multiplier datapath.
REQ-010 The block SHALL have port core_done  input  1  multiplier completion.
REQ-011 The block SHALL have port core_result  input  2*WIDTH  multiplier product.
REQ-012 The block SHALL have ports out_valid  output  1, out_ready  input  1, and out_result  output  2*WIDTH, forming the downstream result handshake.
REQ-013 The block SHALL have port busy  output  1  a job is in flight or the FIFO is non-empty.
REQ-014 The block SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-015 A push SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL equal (level != DEPTH); there is no full-bypass, so a push is refused when full even if a pop occurs in the same cycle.
REQ-017 A push and a pop in the same cycle SHALL leave level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-018 The FSM SHALL be one-hot with states IDLE, ISSUE, WAIT and OUT.
REQ-019 In IDLE with level != 0, the block SHALL pop the head pair into the core_a/core_b registers and go to ISSUE; in IDLE with level = 0, the block SHALL stay in IDLE.
REQ-020 ISSUE SHALL last exactly one cycle with core_start=1, then go to WAIT; core_start SHALL be 0 in every other state.
REQ-021 In WAIT, core_done=1 SHALL capture core_result into out_result and go to OUT; the block SHALL wait indefinitely otherwise.
REQ-022 core_done SHALL be ignored outside WAIT.
REQ-023 In OUT, out_valid SHALL be 1; out_result SHALL be held stable until out_ready=1, then the block SHALL go to IDLE.
REQ-024 out_ready=1 in OUT while the FIFO is full SHALL still transition to IDLE.
REQ-025 core_a and core_b SHALL remain stable from ISSUE until the exit from WAIT.
REQ-026 Latency SHALL be as follows: a pair pushed at edge k into an empty FIFO with the FSM in IDLE gives core_start=1 in the cycle after edge k+1.
REQ-027 Results SHALL be delivered in push order, and core_result SHALL be passed through unmodified.
REQ-028 busy SHALL equal (state != IDLE) | (level != 0).

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, clear the FIFO pointers, and set level=0, core_start=0, out_valid=0, out_result=0, core_a=0 and core_b=0.
REQ-030 Reset mid-operation SHALL discard the in-flight job and all queued pairs; the multiplier shares rst, so no stale core_done follows.
REQ-031 While rst=0, in_ready SHALL be 0 and busy SHALL be 0.

Structure
REQ-032 A shared package SHALL hold the one-hot state constants (IDLE=4'b0001, ISSUE=4'b0010, WAIT=4'b0100, OUT=4'b1000) and the default WIDTH.
REQ-033 The FIFO SHALL be a separate sub-module, op_fifo (params WIDTH, DEPTH; storage of 2*WIDTH bits per entry).

Verification
REQ-034 Basic job: push a=13, b=11; the core model asserts core_done with core_result=16'h1234 ten cycles after core_start -> exactly one core_start pulse, with core_a=13 and core_b=11 held through WAIT; out_valid rises with out_result=16'h1234.
REQ-035 Fill: push 5 pairs back-to-back while the core is stalled -> the 1st pair is issued, the next 4 fill the FIFO to level=4 and in_ready=0, and the 6th pair is not accepted until a pop.
REQ-036 Backpressure: hold out_ready=0 for 20 cycles in OUT -> out_result stays stable, no new core_start occurs, and core_done pulses injected meanwhile are ignored.
REQ-037 Ordering: push pairs (1,2), (3,4), (5,6) with the core model returning distinct tags 0xA1, 0xA2, 0xA3 -> outputs arrive in order 0xA1, 0xA2, 0xA3, and the pointers wrap after a 4th and 5th push.
REQ-038 Reset mid-WAIT with 2 pairs queued -> all outputs are 0 at once and level=0; after release, a new pair (7,9) is processed normally.
REQ-039 Simultaneous push and pop at level=2 -> level stays 2 and no entry is lost or duplicated.
